// File: rtl/i2c_csr_pkg.sv
// i2c_csr_pkg: shared types and defaults for the I2C CSR port scheduler.
package i2c_csr_pkg;

  // Default CSR address width shared by host, engine and CSR file.
  localparam int ADD_WIDTH_DEF = 8;

  // Engine-side access sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    RDATA = 2'd2
  } state_t;

endpackage

// File: rtl/i2c_csr_wait_mon.sv
// i2c_csr_wait_mon: counts how long a pending engine access is held off by
// the host, flags starvation and remembers the worst wait since reset.
module i2c_csr_wait_mon
  import i2c_csr_pkg::*;
#(
  parameter int STARVE_LIM = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 pend,
  input  logic                 blocked,
  input  logic                 issue,
  output logic                 e_starve,
  output logic [CNT_WIDTH-1:0] max_wait
);

  logic [CNT_WIDTH-1:0] cnt_q;

  // Blocked-cycle counter: restarts at every issue and sticks at all-ones.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q <= '0;
    end else if (issue) begin
      cnt_q <= '0;
    end else if (blocked && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  // Worst-case wait is folded in when the access finally reaches the port.
  always_ff @(posedge aclk) begin
    if (areset) begin
      max_wait <= '0;
    end else if (issue && (cnt_q > max_wait)) begin
      max_wait <= cnt_q;
    end
  end

  assign e_starve = pend && (cnt_q >= CNT_WIDTH'(STARVE_LIM));

endmodule

// File: rtl/i2c_csr_port_sched.sv
// i2c_csr_port_sched: shares the single CSR port between the AXI-lite host
// (absolute priority, never stalled) and the I2C byte engine (idle-cycle fill).
module i2c_csr_port_sched
  import i2c_csr_pkg::*;
#(
  parameter int ADD_WIDTH  = ADD_WIDTH_DEF,
  parameter int STARVE_LIM = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [ADD_WIDTH-1:0] h_addr,
  input  logic                 h_wr,
  input  logic [31:0]          h_wdata,
  input  logic                 h_rd,
  output logic [31:0]          h_rdata,
  input  logic                 e_req,
  input  logic                 e_we,
  input  logic [ADD_WIDTH-1:0] e_addr,
  input  logic [31:0]          e_wdata,
  output logic                 e_ready,
  output logic                 e_done,
  output logic [31:0]          e_rdata,
  output logic                 e_starve,
  output logic [CNT_WIDTH-1:0] max_wait,
  output logic                 collide,
  output logic [ADD_WIDTH-1:0] m_addr,
  output logic                 m_wr,
  output logic [31:0]          m_wdata,
  output logic                 m_rd,
  input  logic [31:0]          m_rdata
);

  state_t                 state_q, state_d;
  logic                   host_act;
  logic                   accept;
  logic                   issue;
  logic                   pend;
  logic                   cap_we;
  logic [ADD_WIDTH-1:0]   cap_addr;
  logic [31:0]            cap_wdata;

  assign host_act = h_wr | h_rd;
  assign e_ready  = (state_q == IDLE) & ~areset;
  assign h_rdata  = m_rdata;
  assign pend     = (state_q == PEND) & ~areset;

  // Sequencer state register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: accept in IDLE, issue from PEND only when the host is quiet.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (e_req && e_ready) begin
          accept  = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        if (!host_act && !areset) begin
          issue   = 1'b1;
          state_d = cap_we ? IDLE : RDATA;
        end
      end
      RDATA:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Engine request is latched at accept so the engine can move on.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (accept) begin
      cap_we    <= e_we;
      cap_addr  <= e_addr;
      cap_wdata <= e_wdata;
    end
  end

  // Completion pulse: cycle after a write issue, or after the read data phase.
  always_ff @(posedge aclk) begin
    if (areset) begin
      e_done  <= 1'b0;
      e_rdata <= '0;
    end else begin
      e_done <= (issue && cap_we) || (state_q == RDATA);
      if (state_q == RDATA) begin
        e_rdata <= m_rdata;
      end
    end
  end

  // Sticky record of a host write and read arriving together.
  always_ff @(posedge aclk) begin
    if (areset) begin
      collide <= 1'b0;
    end else if (h_wr && h_rd) begin
      collide <= 1'b1;
    end
  end

  // Port mux: host passes straight through; write wins a host wr/rd clash.
  always_comb begin
    m_wr    = 1'b0;
    m_rd    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (!areset) begin
      if (host_act) begin
        m_wr    = h_wr;
        m_rd    = h_rd & ~h_wr;
        m_addr  = h_addr;
        m_wdata = h_wdata;
      end else if (issue) begin
        m_wr    = cap_we;
        m_rd    = ~cap_we;
        m_addr  = cap_addr;
        m_wdata = cap_wdata;
      end
    end
  end

  i2c_csr_wait_mon #(
    .STARVE_LIM (STARVE_LIM),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_wait_mon (
    .aclk     (aclk),
    .areset   (areset),
    .pend     (pend),
    .blocked  (pend & host_act),
    .issue    (issue),
    .e_starve (e_starve),
    .max_wait (max_wait)
  );

endmodule
